ctrl_event_dispatcher: RTL and testbench

- Parametrised successor to the per-event controller demux pair (field demuxes plus shared selector dispatcher).
- Steers one multi-field event, spread over F_COUNT parallel AXI-Stream field channels, atomically to one of D_COUNT replicated handler instances.
- Every field of an event goes to the same replica. Field 0 may be a multi-beat packet delimited by tlast.
- Adds a credit-based (least-loaded) dispatch mode with per-replica outstanding-event counters, beside round-robin.

---
 rtl/ctrl_event_dispatcher.sv | 186 ++++++++++++++++++
 tb/tb_ctrl_event_dispatcher.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_event_dispatcher.sv
// ctrl_event_dispatcher: steers one multi-field AXI-Stream event atomically to
// one of D_COUNT handler replicas, by round-robin (MODE 0) or least-loaded
// credit selection (MODE 1). Data path is combinational; selection costs one
// idle cycle per event.

// Per-replica outstanding-event counter with sticky underflow flag.
module ctrl_event_dispatcher_credit #(
  parameter int CNT_W           = 3,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             err
);

  // Simultaneous inc/dec cancels; a done on an empty counter flags an error
  // and leaves the count at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (dec && cnt == '0) err <= 1'b1;
      if (inc && !dec && cnt != CNT_W'(MAX_OUTSTANDING))
        cnt <= cnt + CNT_W'(1);
      else if (dec && !inc && cnt != '0)
        cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// Top: event FSM, replica selection, per-field completion tracking.
module ctrl_event_dispatcher #(
  parameter int D_COUNT         = 3,
  parameter int F_COUNT         = 5,
  parameter int FIELD_WIDTH     = 64,
  parameter int MODE            = 0,
  parameter int MAX_OUTSTANDING = 4,
  parameter int SEL_W           = $clog2(D_COUNT),
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [F_COUNT*FIELD_WIDTH-1:0]         s_tdata,
  input  logic [F_COUNT-1:0]                     s_tvalid,
  output logic [F_COUNT-1:0]                     s_tready,
  input  logic [FIELD_WIDTH/8-1:0]               s_tkeep,
  input  logic                                   s_tlast,
  output logic [D_COUNT*F_COUNT*FIELD_WIDTH-1:0] m_tdata,
  output logic [D_COUNT*F_COUNT-1:0]             m_tvalid,
  input  logic [D_COUNT*F_COUNT-1:0]             m_tready,
  output logic [D_COUNT*FIELD_WIDTH/8-1:0]       m_tkeep,
  output logic [D_COUNT-1:0]                     m_tlast,
  input  logic [D_COUNT-1:0]                     done_in,
  output logic [SEL_W-1:0]                       cur_sel,
  output logic                                   busy,
  output logic                                   credit_err
);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t                          state, state_d;
  logic [F_COUNT-1:0]              field_done, field_done_d;
  logic [SEL_W-1:0]                sel_d, rr_ptr, rr_d;
  logic [D_COUNT-1:0][CNT_W-1:0]   cnt;
  logic [D_COUNT-1:0]              lane_err;
  logic [D_COUNT-1:0]              elig, inc, dec;
  logic [D_COUNT-1:0][F_COUNT-1:0] m_rdy;
  logic [F_COUNT-1:0]              sel_rdy, hs, fin;
  logic                            found, dispatch;
  logic [SEL_W-1:0]                pick;
  logic [CNT_W-1:0]                best;
  int                              idx;

  assign busy       = (state == XFER);
  assign credit_err = |lane_err;

  // Payload is broadcast; only the valids are steered.
  assign m_tdata = {D_COUNT{s_tdata}};
  assign m_tkeep = {D_COUNT{s_tkeep}};
  assign m_tlast = {D_COUNT{s_tlast}};
  assign m_rdy   = m_tready;

  // Ready seen by each field comes from the owning replica's matching channel.
  always_comb begin
    sel_rdy = m_rdy[cur_sel];
  end

  assign s_tready = busy ? (~field_done & sel_rdy) : '0;
  assign hs       = s_tvalid & s_tready;

  // Field 0 only completes on its tlast beat; other fields are single-beat.
  always_comb begin
    fin    = hs;
    fin[0] = hs[0] & s_tlast;
  end

  // Per-replica valid steering, credit counters and credit strobes.
  for (genvar r = 0; r < D_COUNT; r++) begin : g_rep
    assign m_tvalid[r*F_COUNT +: F_COUNT] =
      (busy && cur_sel == SEL_W'(r)) ? (s_tvalid & ~field_done) : '0;
    assign inc[r] = (MODE != 0) && dispatch && (pick == SEL_W'(r));
    assign dec[r] = (MODE != 0) && done_in[r];

    ctrl_event_dispatcher_credit #(
      .CNT_W          (CNT_W),
      .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_credit (
      .clk(clk),
      .rst(rst),
      .inc(inc[r]),
      .dec(dec[r]),
      .cnt(cnt[r]),
      .err(lane_err[r])
    );
  end

  // Replica choice: scan from rr_ptr with wrap; MODE 0 takes the first
  // eligible, MODE 1 the lowest count (strict '<' keeps the earliest on ties).
  always_comb begin
    found = 1'b0;
    pick  = '0;
    best  = '0;
    idx   = 0;
    for (int r = 0; r < D_COUNT; r++)
      elig[r] = (MODE == 0) || (cnt[r] < CNT_W'(MAX_OUTSTANDING));
    for (int k = 0; k < D_COUNT; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= D_COUNT) idx = idx - D_COUNT;
      if (elig[idx] && (!found || (MODE != 0 && cnt[idx] < best))) begin
        found = 1'b1;
        pick  = SEL_W'(idx);
        best  = cnt[idx];
      end
    end
  end

  // Next-state: IDLE picks a replica when work and credit exist; XFER runs
  // until every field has completed (including completions this cycle).
  always_comb begin
    state_d      = state;
    field_done_d = field_done;
    sel_d        = cur_sel;
    rr_d         = rr_ptr;
    dispatch     = 1'b0;
    case (state)
      IDLE: begin
        if (|s_tvalid && found) begin
          state_d  = XFER;
          sel_d    = pick;
          rr_d     = (pick == SEL_W'(D_COUNT - 1)) ? '0 : pick + SEL_W'(1);
          dispatch = 1'b1;
        end
      end
      XFER: begin
        if (&(field_done | fin)) begin
          state_d      = IDLE;
          field_done_d = '0;
        end else begin
          field_done_d = field_done | fin;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, completion mask, owner and rotation pointer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      field_done <= '0;
      cur_sel    <= '0;
      rr_ptr     <= '0;
    end else begin
      state      <= state_d;
      field_done <= field_done_d;
      cur_sel    <= sel_d;
      rr_ptr     <= rr_d;
    end
  end

endmodule

// File: tb/tb_ctrl_event_dispatcher.sv
// Bench: two dispatchers (round-robin and credit mode, MAX_OUTSTANDING=2)
// driven from task-based stimulus; a negedge monitor pops per-field
// scoreboard queues and checks replica, data, keep and last of every beat.
module tb_ctrl_event_dispatcher;
  localparam int D  = 3;
  localparam int F  = 5;
  localparam int W  = 16;
  localparam int KW = W / 8;

  typedef struct {
    int            rep;
    logic [W-1:0]  data;
    logic          last;
    logic [KW-1:0] keep;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cycn = 0;
  always @(posedge clk) cycn++;

  int total = 0;
  int bad   = 0;

  logic [F*W-1:0]   sd0, sd1;
  logic [F-1:0]     sv0, sv1, sr0, sr1;
  logic [KW-1:0]    sk0, sk1;
  logic             sl0, sl1;
  logic [D*F*W-1:0] md0, md1;
  logic [D*F-1:0]   mv0, mv1, mtr0, mtr1;
  logic [D*KW-1:0]  mk0, mk1;
  logic [D-1:0]     ml0, ml1;
  logic [D-1:0]     done_in;
  logic [1:0]       cs0, cs1;
  logic             busy0, busy1, ce0, ce1;

  exp_t sbq [2][F][$];

  ctrl_event_dispatcher #(.D_COUNT(D), .F_COUNT(F), .FIELD_WIDTH(W),
                          .MODE(0), .MAX_OUTSTANDING(2)) u0 (
    .clk(clk), .rst(rst), .s_tdata(sd0), .s_tvalid(sv0), .s_tready(sr0),
    .s_tkeep(sk0), .s_tlast(sl0), .m_tdata(md0), .m_tvalid(mv0),
    .m_tready(mtr0), .m_tkeep(mk0), .m_tlast(ml0), .done_in(done_in),
    .cur_sel(cs0), .busy(busy0), .credit_err(ce0));

  ctrl_event_dispatcher #(.D_COUNT(D), .F_COUNT(F), .FIELD_WIDTH(W),
                          .MODE(1), .MAX_OUTSTANDING(2)) u1 (
    .clk(clk), .rst(rst), .s_tdata(sd1), .s_tvalid(sv1), .s_tready(sr1),
    .s_tkeep(sk1), .s_tlast(sl1), .m_tdata(md1), .m_tvalid(mv1),
    .m_tready(mtr1), .m_tkeep(mk1), .m_tlast(ml1), .done_in(done_in),
    .cur_sel(cs1), .busy(busy1), .credit_err(ce1));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mkd(input int base, input int f, input int b);
    return W'(base * 256 + f * 16 + b);
  endfunction

  task automatic mon(input int d, input logic [D*F-1:0] mv, input logic [D*F-1:0] mr,
                     input logic [D*F*W-1:0] md, input logic [D*KW-1:0] mk,
                     input logic [D-1:0] ml);
    exp_t e;
    for (int r = 0; r < D; r++)
      for (int f = 0; f < F; f++)
        if (mv[r*F+f] && mr[r*F+f]) begin
          if (sbq[d][f].size() == 0) begin
            chk("unexp_beat", 0, 1);
          end else begin
            e = sbq[d][f].pop_front();
            chk("rep", r, e.rep);
            chk("data", md[(r*F+f)*W +: W], e.data);
            if (f == 0) begin
              chk("last", ml[r], e.last);
              chk("keep", mk[r*KW +: KW], e.keep);
            end
          end
        end
  endtask

  always @(negedge clk) begin
    mon(0, mv0, mtr0, md0, mk0, ml0);
    mon(1, mv1, mtr1, md1, mk1, ml1);
  end

  task automatic drv(input int d, input logic [F-1:0] v, input logic [F*W-1:0] dat,
                     input logic [KW-1:0] k, input logic l);
    if (d == 0) begin sv0 = v; sd0 = dat; sk0 = k; sl0 = l; end
    else        begin sv1 = v; sd1 = dat; sk1 = k; sl1 = l; end
  endtask

  task automatic pulse_done(input logic [D-1:0] m);
    done_in = m;
    @(posedge clk); #1;
    done_in = '0;
  endtask

  // One event: pushes expectations, then drives fields cycle by cycle until
  // every field has handshaken (bounded), with optional field-3 skew,
  // replica-1 ready toggling, stall checks and a done_in pulse at cycle dn_cyc.
  task automatic run_event(input int d, input int rep, input int beats, input int base,
                           input int skew3, input bit tog, input bit chkb,
                           input int stall, input int dn_cyc, input logic [D-1:0] dn_mask,
                           output int n_out);
    exp_t e;
    logic [F-1:0]   pend, v, rdy, hs;
    logic [F*W-1:0] dat;
    int beat, n;
    for (int b = 0; b < beats; b++) begin
      e.rep = rep; e.data = mkd(base, 0, b); e.last = (b == beats - 1);
      e.keep = (b == beats - 1) ? 2'b01 : 2'b11;
      sbq[d][0].push_back(e);
    end
    for (int f = 1; f < F; f++) begin
      e.rep = rep; e.data = mkd(base, f, 0); e.last = 1'b0; e.keep = '0;
      sbq[d][f].push_back(e);
    end
    pend = '1; beat = 0; n = 0;
    while (pend != '0 && n < 60) begin
      done_in = (n == dn_cyc) ? dn_mask : '0;
      if (tog) mtr0[F +: F] = n[0] ? '0 : '1;
      for (int f = 0; f < F; f++) begin
        v[f] = pend[f] && !(f == 3 && n < skew3);
        dat[f*W +: W] = mkd(base, f, (f == 0) ? beat : 0);
      end
      drv(d, v, dat, (beat == beats - 1) ? 2'b01 : 2'b11, beat == beats - 1);
      @(negedge clk);
      rdy = (d == 0) ? sr0 : sr1;
      hs  = v & rdy;
      if (n < stall) begin
        chk("stall_rdy", rdy, 0);
        chk("stall_busy", (d == 0) ? busy0 : busy1, 0);
      end
      if (chkb && n >= 1 && pend[3]) chk("skew_busy", busy0, 1);
      @(posedge clk); #1;
      for (int f = 0; f < F; f++)
        if (hs[f]) begin
          if (f == 0 && beat != beats - 1) beat++;
          else pend[f] = 1'b0;
        end
      n++;
    end
    drv(d, '0, '0, '0, 1'b0);
    done_in = '0;
    mtr0 = '1;
    chk("tmo_pend", pend, 0);
    n_out = n;
  endtask

  initial begin : main
    int n, c0;
    exp_t e;
    done_in = '0; mtr0 = '1; mtr1 = '1;
    drv(0, '0, '0, '0, 1'b0);
    drv(1, '0, '0, '0, 1'b0);
    #2;
    chk("rst_busy0", busy0, 0);
    chk("rst_busy1", busy1, 0);
    chk("rst_srdy0", sr0, 0);
    chk("rst_mvld0", mv0, 0);
    chk("rst_mvld1", mv1, 0);
    chk("rst_sel1", cs1, 0);
    chk("rst_cerr1", ce1, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Round-robin, back to back, 2 cycles per event.
    c0 = cycn;
    for (int i = 0; i < 6; i++) begin
      run_event(0, i % 3, 1, i + 1, 0, 1'b0, 1'b0, 0, -1, '0, n);
      chk("rr_sel", cs0, i % 3);
    end
    chk("rr_cycles", cycn - c0, 12);

    // Skewed field 3, 3-beat packet, toggling ready on replica 1.
    run_event(0, 0, 1, 7, 0, 1'b0, 1'b0, 0, -1, '0, n);
    run_event(0, 1, 3, 8, 4, 1'b1, 1'b1, 0, -1, '0, n);
    chk("skew_sel", cs0, 1);
    chk("skew_idle", busy0, 0);

    // Credit mode: 6 dispatches fill every replica to 2.
    for (int i = 0; i < 6; i++) begin
      run_event(1, i % 3, 1, 16 + i, 0, 1'b0, 1'b0, 0, -1, '0, n);
      chk("cr_sel", cs1, i % 3);
    end
    // 7th stalls until a done on replica 1.
    run_event(1, 1, 1, 23, 0, 1'b0, 1'b0, 5, 5, 3'b010, n);
    chk("cr7_sel", cs1, 1);
    chk("cr7_lat", n, 8);

    // Counts -> {2,0,1}; done on 0 in the pick cycle: least loaded is 1.
    pulse_done(3'b010);
    pulse_done(3'b010);
    pulse_done(3'b100);
    run_event(1, 1, 1, 24, 0, 1'b0, 1'b0, 0, 0, 3'b001, n);
    chk("least_sel", cs1, 1);
    // All at 1; dispatch + done on replica 2 together.
    run_event(1, 2, 1, 25, 0, 1'b0, 1'b0, 0, 0, 3'b100, n);
    chk("same_sel", cs1, 2);
    // If cnt[2] stayed 1, exactly one more fits on 2, then a stall.
    run_event(1, 0, 1, 26, 0, 1'b0, 1'b0, 0, -1, '0, n);
    run_event(1, 1, 1, 27, 0, 1'b0, 1'b0, 0, -1, '0, n);
    run_event(1, 2, 1, 28, 0, 1'b0, 1'b0, 0, -1, '0, n);
    run_event(1, 0, 1, 29, 0, 1'b0, 1'b0, 4, 4, 3'b001, n);
    chk("full_lat", n, 7);

    // Underflow on replica 2.
    pulse_done(3'b100);
    pulse_done(3'b100);
    chk("cerr_clean", ce1, 0);
    pulse_done(3'b100);
    chk("cerr_set", ce1, 1);
    run_event(1, 2, 1, 30, 0, 1'b0, 1'b0, 0, -1, '0, n);
    run_event(1, 2, 1, 31, 0, 1'b0, 1'b0, 0, -1, '0, n);
    chk("cerr_sticky", ce1, 1);
    chk("cerr_sel", cs1, 2);

    // Reset mid-packet: beats 0,1 delivered, reset before beat 2.
    pulse_done(3'b010);
    for (int f = 1; f < F; f++) begin
      e.rep = 1; e.data = mkd(9, f, 0); e.last = 1'b0; e.keep = '0;
      sbq[1][f].push_back(e);
    end
    for (int b = 0; b < 2; b++) begin
      e.rep = 1; e.data = mkd(9, 0, b); e.last = 1'b0; e.keep = 2'b11;
      sbq[1][0].push_back(e);
    end
    begin
      logic [F*W-1:0] dat;
      for (int f = 0; f < F; f++) dat[f*W +: W] = mkd(9, f, 0);
      drv(1, '1, dat, 2'b11, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      dat[W-1:0] = mkd(9, 0, 1);
      drv(1, 5'b00001, dat, 2'b11, 1'b0);
      @(posedge clk); #1;
      dat[W-1:0] = mkd(9, 0, 2);
      drv(1, 5'b00001, dat, 2'b11, 1'b0);
      #1 rst = 1'b0;
      #1;
    end
    chk("mrst_mvld", mv1, 0);
    chk("mrst_busy", busy1, 0);
    chk("mrst_srdy", sr1, 0);
    chk("mrst_sel", cs1, 0);
    chk("mrst_cerr", ce1, 0);
    chk("mrst_sbq", sbq[1][0].size() + sbq[1][1].size(), 0);
    drv(1, '0, '0, '0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    run_event(1, 0, 1, 40, 0, 1'b0, 1'b0, 0, -1, '0, n);
    chk("post_sel", cs1, 0);

    begin
      int left;
      left = 0;
      for (int d = 0; d < 2; d++)
        for (int f = 0; f < F; f++) left += sbq[d][f].size();
      chk("sb_left", left, 0);
    end
    chk("m0_cerr", ce0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
